// File: rtl/pll_clkgen_pkg.sv
// Shared constants and types for the pll_clkgen NCO clock generator.
package pll_clkgen_pkg;

    localparam int ACC_W_DEFAULT = 32;

    typedef logic [ACC_W_DEFAULT-1:0] tune_word_t;

    // Channel 1 runs at exactly 7x channel 0 (f_ref/32 and 7*f_ref/32).
    localparam tune_word_t INC0_DEFAULT = 32'h0800_0000;
    localparam tune_word_t INC1_DEFAULT = 32'h3800_0000;

    localparam int LOCK_CNT_W = 16;

endpackage

// File: rtl/pll_clkgen_if.sv
// Output bundle of pll_clkgen. This is a plain broadcast of three
// free-running signals. There is no valid/ready handshake: a consumer
// samples them on any refclk edge.
interface pll_clkgen_if;

    logic clk0_out;
    logic clk1_out;
    logic locked;

    modport master (output clk0_out, output clk1_out, output locked);
    modport slave  (input  clk0_out, input  clk1_out, input  locked);

endinterface

// File: rtl/pll_clkgen_nco.sv
// nco_channel: one phase-accumulator channel. The square-wave output is
// the accumulator MSB taken straight from the register, so it cannot glitch.
module nco_channel
    import pll_clkgen_pkg::*;
#(
    parameter int               ACC_W = ACC_W_DEFAULT,
    parameter logic [ACC_W-1:0] INC   = ACC_W'(INC0_DEFAULT)
) (
    input  logic refclk,
    input  logic reset,
    output logic phase_msb
);

    logic [ACC_W-1:0] acc;

    // Advance the phase by INC each cycle. The carry out of the top bit is dropped.
    always_ff @(posedge refclk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc + INC;
        end
    end

    assign phase_msb = acc[ACC_W-1];

endmodule

// File: rtl/pll_clkgen.sv
// pll_clkgen: digital PLL stand-in built from two NCO channels and a
// lock timer.
// Optional build macro PLL_CLKGEN_GATE_UNTIL_LOCK_EN holds both clock
// outputs low until locked. The accumulators keep running while the
// outputs are held.
module pll_clkgen
    import pll_clkgen_pkg::*;
#(
    parameter int         ACC_W       = ACC_W_DEFAULT,
    parameter tune_word_t INC0        = INC0_DEFAULT,
    parameter tune_word_t INC1        = INC1_DEFAULT,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              reset,
    pll_clkgen_if.master      pll_if
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(LOCK_CYCLES);

    logic                  msb0;
    logic                  msb1;
    logic                  locked_w;
    logic [LOCK_CNT_W-1:0] lock_cnt;

    nco_channel #(.ACC_W(ACC_W), .INC(ACC_W'(INC0))) u_nco0 (
        .refclk    (refclk),
        .reset     (reset),
        .phase_msb (msb0)
    );

    nco_channel #(.ACC_W(ACC_W), .INC(ACC_W'(INC1))) u_nco1 (
        .refclk    (refclk),
        .reset     (reset),
        .phase_msb (msb1)
    );

    // Count cycles since reset release and stop at LOCK_CYCLES.
    always_ff @(posedge refclk) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign locked_w      = (lock_cnt == LOCK_MAX);
    assign pll_if.locked = locked_w;

`ifdef PLL_CLKGEN_GATE_UNTIL_LOCK_EN
    assign pll_if.clk0_out = msb0 & locked_w;
    assign pll_if.clk1_out = msb1 & locked_w;
`else
    assign pll_if.clk0_out = msb0;
    assign pll_if.clk1_out = msb1;
`endif

endmodule

// File: tb/tb_pll_clkgen.sv
// Self-checking bench for pll_clkgen. It runs three configurations side by
// side from one refclk and one reset:
//   a: default tuning, lock after 16 cycles
//   b: INC0 = half scale, INC1 = 0
//   c: default tuning, lock after 40 cycles
// Expected values come from the closed form acc = k*INC mod 2^32, where k
// is the number of edges since reset release.
module tb_pll_clkgen;
    import pll_clkgen_pkg::*;

    logic refclk;
    logic reset;

    pll_clkgen_if if_a ();
    pll_clkgen_if if_b ();
    pll_clkgen_if if_c ();

    pll_clkgen dut_a (.refclk(refclk), .reset(reset), .pll_if(if_a));

    pll_clkgen #(.INC0(32'h8000_0000), .INC1(32'h0000_0000)) dut_b (
        .refclk(refclk), .reset(reset), .pll_if(if_b));

    pll_clkgen #(.LOCK_CYCLES(40)) dut_c (
        .refclk(refclk), .reset(reset), .pll_if(if_c));

    // clock / reset
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int              n_cmp;
    int              n_bad;
    longint unsigned k;

    // Reference model
    function automatic logic raw_msb(longint unsigned kk, logic [31:0] inc);
        logic [63:0] p;
        p = 64'(kk) * {32'd0, inc};
        return p[31];
    endfunction

    function automatic logic exp_lock(longint unsigned kk, int lc);
        return (kk >= 64'(lc));
    endfunction

    function automatic logic exp_clk(longint unsigned kk, logic [31:0] inc, int lc);
`ifdef PLL_CLKGEN_GATE_UNTIL_LOCK_EN
        return raw_msb(kk, inc) & exp_lock(kk, lc);
`else
        return raw_msb(kk, inc);
`endif
    endfunction

    // Driver: apply reset for one edge, then sample 1 time unit after that edge.
    task automatic tick(input logic r);
        reset = r;
        @(posedge refclk);
        #1;
        if (r) k = 0;
        else   k = k + 1;
    endtask

    task automatic test_reset();
        tick(1'b1);
        tick(1'b1);
        n_cmp++; if (if_a.clk0_out !== 1'b0) begin n_bad++; $display("FAIL reset_a_clk0 got %b want 0", if_a.clk0_out); end
        n_cmp++; if (if_a.clk1_out !== 1'b0) begin n_bad++; $display("FAIL reset_a_clk1 got %b want 0", if_a.clk1_out); end
        n_cmp++; if (if_a.locked   !== 1'b0) begin n_bad++; $display("FAIL reset_a_lock got %b want 0", if_a.locked); end
        n_cmp++; if (if_b.clk0_out !== 1'b0) begin n_bad++; $display("FAIL reset_b_clk0 got %b want 0", if_b.clk0_out); end
        n_cmp++; if (if_c.locked   !== 1'b0) begin n_bad++; $display("FAIL reset_c_lock got %b want 0", if_c.locked); end
    endtask

    task automatic test_clk0_default();
        int   rises;
        logic prev;
        logic e;
        tick(1'b1);
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick(1'b0);
            e = exp_clk(k, INC0_DEFAULT, 16);
            n_cmp++;
            if (if_a.clk0_out !== e) begin
                n_bad++; $display("FAIL clk0_default edge %0d got %b want %b", k, if_a.clk0_out, e);
            end
            if (if_a.clk0_out === 1'b1 && prev === 1'b0) rises++;
            prev = if_a.clk0_out;
        end
        n_cmp++;
        if (rises !== 2) begin n_bad++; $display("FAIL clk0_rises64 got %0d want 2", rises); end
    endtask

    task automatic test_clk1_ratio();
        int   r0, r1;
        logic p0, p1;
        logic e;
        tick(1'b1);
        r0 = 0; r1 = 0; p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 320; i++) begin
            tick(1'b0);
            e = exp_clk(k, INC1_DEFAULT, 16);
            n_cmp++;
            if (if_a.clk1_out !== e) begin
                n_bad++; $display("FAIL clk1_phase edge %0d got %b want %b", k, if_a.clk1_out, e);
            end
            if (if_a.clk0_out === 1'b1 && p0 === 1'b0) r0++;
            if (if_a.clk1_out === 1'b1 && p1 === 1'b0) r1++;
            p0 = if_a.clk0_out;
            p1 = if_a.clk1_out;
        end
        n_cmp++; if (r1 !== 70) begin n_bad++; $display("FAIL clk1_rises320 got %0d want 70", r1); end
        n_cmp++; if (r0 !== 10) begin n_bad++; $display("FAIL clk0_rises320 got %0d want 10", r0); end
    endtask

    task automatic test_lock();
        tick(1'b1);
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0);
            n_cmp++;
            if (if_a.locked !== exp_lock(k, 16)) begin
                n_bad++; $display("FAIL lock16 edge %0d got %b want %b", k, if_a.locked, exp_lock(k, 16));
            end
            n_cmp++;
            if (if_c.locked !== exp_lock(k, 40)) begin
                n_bad++; $display("FAIL lock40 edge %0d got %b want %b", k, if_c.locked, exp_lock(k, 40));
            end
        end
        n_cmp++;
        if (if_a.locked !== 1'b1) begin n_bad++; $display("FAIL lock_at_1000 got %b want 1", if_a.locked); end
    endtask

    task automatic test_mid_reset();
        int first_rise;
        tick(1'b1);
        for (int i = 0; i < 100; i++) tick(1'b0);
        tick(1'b1);
        n_cmp++; if (if_a.clk0_out !== 1'b0) begin n_bad++; $display("FAIL midrst_clk0 got %b want 0", if_a.clk0_out); end
        n_cmp++; if (if_a.clk1_out !== 1'b0) begin n_bad++; $display("FAIL midrst_clk1 got %b want 0", if_a.clk1_out); end
        n_cmp++; if (if_a.locked   !== 1'b0) begin n_bad++; $display("FAIL midrst_lock got %b want 0", if_a.locked); end
        first_rise = -1;
        for (int i = 1; i <= 40 && first_rise < 0; i++) begin
            tick(1'b0);
            if (if_a.clk0_out === 1'b1) first_rise = i;
        end
        n_cmp++;
        if (first_rise !== 16) begin n_bad++; $display("FAIL midrst_first_rise got %0d want 16", first_rise); end
    endtask

    task automatic test_override();
        logic e0, e1;
        tick(1'b1);
        for (int i = 0; i < 64; i++) begin
            tick(1'b0);
            e0 = exp_clk(k, 32'h8000_0000, 16);
            e1 = exp_clk(k, 32'h0000_0000, 16);
            n_cmp++;
            if (if_b.clk0_out !== e0) begin n_bad++; $display("FAIL ovr_clk0 edge %0d got %b want %b", k, if_b.clk0_out, e0); end
            n_cmp++;
            if (if_b.clk1_out !== e1) begin n_bad++; $display("FAIL ovr_clk1 edge %0d got %b want %b", k, if_b.clk1_out, e1); end
        end
    endtask

    task automatic test_gate();
        logic e0, e1;
        tick(1'b1);
        for (int i = 0; i < 80; i++) begin
            tick(1'b0);
            e0 = exp_clk(k, INC0_DEFAULT, 40);
            e1 = exp_clk(k, INC1_DEFAULT, 40);
            n_cmp++;
            if (if_c.clk0_out !== e0) begin n_bad++; $display("FAIL gate_clk0 edge %0d got %b want %b", k, if_c.clk0_out, e0); end
            n_cmp++;
            if (if_c.clk1_out !== e1) begin n_bad++; $display("FAIL gate_clk1 edge %0d got %b want %b", k, if_c.clk1_out, e1); end
        end
    endtask

    task automatic test_random();
        logic r;
        int   hold;
        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0 && $urandom_range(0, 99) == 0) hold = $urandom_range(1, 3);
            r = (hold > 0);
            if (hold > 0) hold--;
            tick(r);
            n_cmp++;
            if (if_a.clk0_out !== exp_clk(k, INC0_DEFAULT, 16) || if_a.clk1_out !== exp_clk(k, INC1_DEFAULT, 16)
                || if_a.locked !== exp_lock(k, 16)) begin
                n_bad++; $display("FAIL rand_a k=%0d got %b%b%b want %b%b%b", k, if_a.clk0_out, if_a.clk1_out, if_a.locked,
                                  exp_clk(k, INC0_DEFAULT, 16), exp_clk(k, INC1_DEFAULT, 16), exp_lock(k, 16));
            end
            n_cmp++;
            if (if_b.clk0_out !== exp_clk(k, 32'h8000_0000, 16) || if_b.clk1_out !== exp_clk(k, 32'h0, 16)
                || if_b.locked !== exp_lock(k, 16)) begin
                n_bad++; $display("FAIL rand_b k=%0d got %b%b%b want %b%b%b", k, if_b.clk0_out, if_b.clk1_out, if_b.locked,
                                  exp_clk(k, 32'h8000_0000, 16), exp_clk(k, 32'h0, 16), exp_lock(k, 16));
            end
            n_cmp++;
            if (if_c.clk0_out !== exp_clk(k, INC0_DEFAULT, 40) || if_c.clk1_out !== exp_clk(k, INC1_DEFAULT, 40)
                || if_c.locked !== exp_lock(k, 40)) begin
                n_bad++; $display("FAIL rand_c k=%0d got %b%b%b want %b%b%b", k, if_c.clk0_out, if_c.clk1_out, if_c.locked,
                                  exp_clk(k, INC0_DEFAULT, 40), exp_clk(k, INC1_DEFAULT, 40), exp_lock(k, 40));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        k     = 0;
        reset = 1'b1;
        test_reset();
        test_clk0_default();
        test_clk1_ratio();
        test_lock();
        test_mid_reset();
        test_override();
        test_gate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
